// File: rtl/pspin_cfg_pkg.sv
// Shared configuration for the cluster command path: command type,
// source-tag type and default sizing for the command concentrator.
package pspin_cfg_pkg;

  localparam int unsigned CLUSTER_CMD_NUM_CORES       = 8;
  localparam int unsigned CLUSTER_CMD_FIFO_DEPTH      = 2;
  localparam int unsigned CLUSTER_CMD_MAX_OUTSTANDING = 4;
  localparam int unsigned CLUSTER_CMD_CORE_ID_W       = $clog2(CLUSTER_CMD_NUM_CORES);

  // Command issued by an HPU driver towards the uncluster command unit.
  typedef struct packed {
    logic [3:0]  cmd_type;
    logic [27:0] arg;
  } pspin_cmd_t;

  // Core index attached to every command leaving the cluster.
  typedef logic [CLUSTER_CMD_CORE_ID_W-1:0] cmd_src_t;

endpackage

// File: rtl/cluster_cmd_fifo.sv
// Single-clock command FIFO with full/empty flags. Read data is the head
// entry, presented combinationally; a pop consumes it on the next edge.
module cluster_cmd_fifo
  import pspin_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  pspin_cmd_t data_i,
  input  logic       pop_i,
  output pspin_cmd_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pspin_cmd_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags and head data come from registered state only.
  always_comb begin
    full_o  = (cnt_q == CNT_W'(DEPTH));
    empty_o = (cnt_q == '0);
    data_o  = mem_q[rd_ptr_q];
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
  end

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cluster_cmd_arb.sv
// Per-cluster command concentrator: one FIFO per core, round-robin
// arbitration, a single-entry output slice tagged with the source core,
// and per-core outstanding-command throttling driven by completions.
//
// Handshake rule on every valid/ready pair here: a transfer happens on a
// rising clk_i edge where valid and ready are both high; once valid is
// raised it stays high with stable payload until that transfer happens.
module cluster_cmd_arb
  import pspin_cfg_pkg::*;
#(
  parameter  int unsigned NUM_CORES       = CLUSTER_CMD_NUM_CORES,
  parameter  int unsigned FIFO_DEPTH      = CLUSTER_CMD_FIFO_DEPTH,
  parameter  int unsigned MAX_OUTSTANDING = CLUSTER_CMD_MAX_OUTSTANDING,
  localparam int unsigned CORE_ID_W       = $clog2(NUM_CORES),
  localparam int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic       [NUM_CORES-1:0]          cmd_valid_i,
  output logic       [NUM_CORES-1:0]          cmd_ready_o,
  input  pspin_cmd_t [NUM_CORES-1:0]          cmd_i,
  output logic                                cmd_valid_o,
  input  logic                                cmd_ready_i,
  output pspin_cmd_t                          cmd_o,
  output logic       [CORE_ID_W-1:0]          cmd_src_o,
  input  logic                                cmd_resp_valid_i,
  input  logic       [CORE_ID_W-1:0]          cmd_resp_core_i,
  output logic       [NUM_CORES-1:0][OUT_W-1:0] outstanding_o,
  output logic                                err_o
);

  logic       [NUM_CORES-1:0] fifo_full, fifo_empty, fifo_pop, eligible;
  pspin_cmd_t                 fifo_data [NUM_CORES];

  logic                           valid_q;
  pspin_cmd_t                     cmd_q;
  logic [CORE_ID_W-1:0]           src_q, rr_ptr_q, rr_ptr_d, winner;
  logic [NUM_CORES-1:0][OUT_W-1:0] out_q, out_d;
  logic                           err_q, err_d;
  logic                           found, load, hs, grant, resp_in_range;
  int                             arb_idx;

  for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_fifo
    cluster_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cmd_valid_i[g]),
      .data_i  (cmd_i[g]),
      .pop_i   (fifo_pop[g]),
      .data_o  (fifo_data[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  // Ready is pure FIFO space; throttling never blocks buffering.
  assign cmd_ready_o   = ~fifo_full;
  assign cmd_valid_o   = valid_q;
  assign cmd_o         = cmd_q;
  assign cmd_src_o     = src_q;
  assign outstanding_o = out_q;
  assign err_o         = err_q;

  // Eligibility counts the command parked in the slice against its core.
  always_comb begin
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      eligible[i] = !fifo_empty[i] &&
                    ((32'(out_q[i]) + 32'(valid_q && (src_q == CORE_ID_W'(i))))
                     < MAX_OUTSTANDING);
    end
  end

  // Round-robin pick: first eligible core at or after the pointer.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    arb_idx  = 0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= int'(NUM_CORES)) arb_idx = arb_idx - int'(NUM_CORES);
      if (!found && eligible[arb_idx]) begin
        found  = 1'b1;
        winner = CORE_ID_W'(arb_idx);
      end
    end
    hs       = valid_q && cmd_ready_i;
    load     = !valid_q || cmd_ready_i;
    grant    = load && found;
    fifo_pop = '0;
    if (grant) fifo_pop[winner] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (winner == CORE_ID_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
  end

  // Outstanding bookkeeping; coinciding issue and completion cancel out.
  always_comb begin
    out_d         = out_q;
    err_d         = err_q;
    resp_in_range = (32'(cmd_resp_core_i) < NUM_CORES);
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (hs && (src_q == CORE_ID_W'(i)) &&
          !(cmd_resp_valid_i && resp_in_range && (cmd_resp_core_i == CORE_ID_W'(i)))) begin
        out_d[i] = out_q[i] + 1'b1;
      end else if (!(hs && (src_q == CORE_ID_W'(i))) &&
                   cmd_resp_valid_i && resp_in_range &&
                   (cmd_resp_core_i == CORE_ID_W'(i))) begin
        if (out_q[i] == '0) err_d = 1'b1;
        else                out_d[i] = out_q[i] - 1'b1;
      end
    end
    if (cmd_resp_valid_i && !resp_in_range) err_d = 1'b1;
  end

  // Output slice, arbitration pointer, counters and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      cmd_q    <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= grant;
        if (grant) begin
          cmd_q <= fifo_data[winner];
          src_q <= winner;
        end
      end
      rr_ptr_q <= rr_ptr_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_cluster_cmd_arb.sv
// Directed bench for cluster_cmd_arb: drivers push commands, each test
// queues the hand-derived output order, and a monitor pops and compares
// on every output transfer while also watching stall stability.
module tb_cluster_cmd_arb;
  import pspin_cfg_pkg::*;

  localparam int N  = 8;
  localparam int CW = 3;
  localparam int OW = 3;

  logic                     clk = 1'b0;
  logic                     rst_ni = 1'b0;
  logic       [N-1:0]       cmd_valid_i = '0;
  logic       [N-1:0]       cmd_ready_o;
  pspin_cmd_t [N-1:0]       cmd_i = '0;
  logic                     cmd_valid_o;
  logic                     cmd_ready_i = 1'b0;
  pspin_cmd_t               cmd_o;
  logic       [CW-1:0]      cmd_src_o;
  logic                     cmd_resp_valid_i = 1'b0;
  logic       [CW-1:0]      cmd_resp_core_i = '0;
  logic       [N-1:0][OW-1:0] outstanding_o;
  logic                     err_o;

  int checks = 0;
  int errors = 0;
  logic [CW+31:0] exp_q[$];

  cluster_cmd_arb dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_i            (cmd_i),
    .cmd_valid_o      (cmd_valid_o),
    .cmd_ready_i      (cmd_ready_i),
    .cmd_o            (cmd_o),
    .cmd_src_o        (cmd_src_o),
    .cmd_resp_valid_i (cmd_resp_valid_i),
    .cmd_resp_core_i  (cmd_resp_core_i),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pspin_cmd_t mk_cmd(input int core, input int seq);
    pspin_cmd_t c;
    c = {4'hA, 20'h0, 4'(core), 4'(seq)};
    return c;
  endfunction

  task automatic exp_push(input int core, input int seq);
    exp_q.push_back({CW'(core), mk_cmd(core, seq)});
  endtask

  // Drivers: called at posedge+1; return at posedge+1 after acceptance.
  task automatic push_mask(input logic [N-1:0] mask, input int seq);
    logic [N-1:0] pend, acc;
    int budget;
    pend = mask;
    budget = 0;
    for (int c = 0; c < N; c++) if (mask[c]) cmd_i[c] = mk_cmd(c, seq);
    while (pend != '0) begin
      cmd_valid_i = pend;
      @(negedge clk);
      acc = pend & cmd_ready_o;
      @(posedge clk);
      #1;
      pend = pend & ~acc;
      budget++;
      if (budget > 50) begin
        chk("push_timeout", 64'(pend), 64'(0));
        pend = '0;
      end
    end
    cmd_valid_i = '0;
  endtask

  task automatic push1(input int core, input int seq);
    push_mask(N'(1) << core, seq);
  endtask

  task automatic send_resp(input int core);
    cmd_resp_valid_i = 1'b1;
    cmd_resp_core_i  = CW'(core);
    @(posedge clk);
    #1;
    cmd_resp_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cmd_valid_i = '0;
    cmd_resp_valid_i = 1'b0;
    cmd_ready_i = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cmd_valid_o) break;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor and stall-stability watcher
  logic           prev_stall = 1'b0;
  pspin_cmd_t     prev_cmd;
  logic [CW-1:0]  prev_src;
  logic [CW+31:0] exp_e;
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(cmd_valid_o), 64'(1));
        chk("hold_cmd", 64'(cmd_o), 64'(prev_cmd));
        chk("hold_src", 64'(cmd_src_o), 64'(prev_src));
      end
      if (cmd_valid_o && cmd_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got src %0d cmd %0h expected none", cmd_src_o, cmd_o);
        end else begin
          exp_e = exp_q.pop_front();
          chk("out_cmd", 64'({cmd_src_o, cmd_o}), 64'(exp_e));
        end
      end
      prev_stall = cmd_valid_o && !cmd_ready_i;
      prev_cmd   = cmd_o;
      prev_src   = cmd_src_o;
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed tests and final report
  initial begin
    int run;
    bit started;

    // Reset values while reset is asserted
    #1;
    chk("rst_valid", 64'(cmd_valid_o), 64'(0));
    chk("rst_cmd", 64'(cmd_o), 64'(0));
    chk("rst_src", 64'(cmd_src_o), 64'(0));
    chk("rst_out", 64'(outstanding_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready_o), 64'hFF);
    @(posedge clk);
    #1;

    // Single command from core 3, two-cycle latency
    cmd_ready_i = 1'b1;
    exp_push(3, 1);
    push1(3, 1);
    @(negedge clk);
    chk("lat_early", 64'(cmd_valid_o), 64'(0));
    @(negedge clk);
    chk("lat_valid", 64'(cmd_valid_o), 64'(1));
    chk("lat_src", 64'(cmd_src_o), 64'(3));
    @(negedge clk);
    chk("single_out3", 64'(outstanding_o[3]), 64'(1));
    wait_drain();

    // Fairness: every core two commands, full throughput
    do_reset();
    cmd_ready_i = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < N; c++) exp_push(c, s);
    push_mask(8'hFF, 0);
    push_mask(8'hFF, 1);
    run = 0;
    started = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (cmd_valid_o) begin
        started = 1'b1;
        run++;
      end else if (started) begin
        break;
      end
    end
    chk("fair_run", 64'(run), 64'(16));
    wait_drain();

    // Backpressure on core 2
    do_reset();
    cmd_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) exp_push(2, s);
    for (int s = 0; s < 3; s++) push1(2, s);
    cycles(5);
    chk("bp_ready2", 64'(cmd_ready_o[2]), 64'(0));
    chk("bp_valid", 64'(cmd_valid_o), 64'(1));
    chk("bp_src", 64'(cmd_src_o), 64'(2));
    chk("bp_cmd", 64'(cmd_o), 64'(mk_cmd(2, 0)));
    cmd_ready_i = 1'b1;
    wait_drain();

    // Outstanding limit on core 0
    do_reset();
    cmd_ready_i = 1'b1;
    for (int s = 0; s < 4; s++) exp_push(0, s);
    for (int s = 0; s < 6; s++) push1(0, s);
    exp_push(1, 0);
    push1(1, 0);
    cycles(6);
    chk("lim_out0", 64'(outstanding_o[0]), 64'(4));
    chk("lim_out1", 64'(outstanding_o[1]), 64'(1));
    chk("lim_valid", 64'(cmd_valid_o), 64'(0));
    chk("lim_ready0", 64'(cmd_ready_o[0]), 64'(0));
    chk("lim_exp", 64'(exp_q.size()), 64'(0));
    exp_push(0, 4);
    send_resp(0);
    cycles(6);
    chk("lim_out0_after", 64'(outstanding_o[0]), 64'(4));
    chk("lim_exp_after", 64'(exp_q.size()), 64'(0));
    chk("lim_valid_after", 64'(cmd_valid_o), 64'(0));

    // Same-cycle issue and completion on core 5
    do_reset();
    cmd_ready_i = 1'b1;
    exp_push(5, 0);
    push1(5, 0);
    cycles(4);
    chk("sc_out5_pre", 64'(outstanding_o[5]), 64'(1));
    cmd_ready_i = 1'b0;
    exp_push(5, 1);
    push1(5, 1);
    cycles(3);
    chk("sc_valid", 64'(cmd_valid_o), 64'(1));
    cmd_ready_i = 1'b1;
    cmd_resp_valid_i = 1'b1;
    cmd_resp_core_i = CW'(5);
    @(posedge clk);
    #1;
    cmd_resp_valid_i = 1'b0;
    cmd_ready_i = 1'b0;
    @(negedge clk);
    chk("sc_out5", 64'(outstanding_o[5]), 64'(1));
    chk("sc_err", 64'(err_o), 64'(0));
    @(posedge clk);
    #1;

    // Completion to an idle core sets the sticky error
    send_resp(6);
    @(negedge clk);
    chk("err_set", 64'(err_o), 64'(1));
    chk("err_out6", 64'(outstanding_o[6]), 64'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled burst
    push_mask(8'h0F, 2);
    cycles(2);
    chk("mid_valid_pre", 64'(cmd_valid_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_valid", 64'(cmd_valid_o), 64'(0));
    chk("mid_err", 64'(err_o), 64'(0));
    chk("mid_out", 64'(outstanding_o), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cmd_ready_i = 1'b1;
    cycles(5);
    chk("mid_flushed", 64'(cmd_valid_o), 64'(0));
    chk("mid_ready", 64'(cmd_ready_o), 64'hFF);

    chk("final_exp", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_cmd_arb.md
Name: cluster_cmd_arb

Overview:
Per-cluster command concentrator between the HPU drivers and the uncluster command unit; successor to the unbuffered single-arbiter command path. Each core gets a FIFO of FIFO_DEPTH commands. A round-robin arbiter selects among the cores. A register slice drives the output, and each source is tagged with its core index. A per-core outstanding-command limit is enforced using completion feedback from the uncluster.

Parameters:
NUM_CORES, 8, number of HPU command sources (>=2)
FIFO_DEPTH, 2, entries per core input FIFO (>=1)
MAX_OUTSTANDING, 4, max issued-but-uncompleted commands per core (>=1)
CORE_ID_W, $clog2(NUM_CORES), derived; width of core index

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
cmd_valid_i  in  NUM_CORES  per-core command valid
cmd_ready_o  out  NUM_CORES  per-core ready; high when that core's FIFO is not full
cmd_i  in  NUM_CORES x pspin_cmd_t  per-core command
cmd_valid_o  out  1  command valid to uncluster
cmd_ready_i  in  1  uncluster ready
cmd_o  out  pspin_cmd_t  selected command
cmd_src_o  out  CORE_ID_W  index of the core that issued cmd_o
cmd_resp_valid_i  in  1  a previously issued command completed
cmd_resp_core_i  in  CORE_ID_W  core index of the completion
outstanding_o  out  NUM_CORES x $clog2(MAX_OUTSTANDING+1)  per-core outstanding count
err_o  out  1  sticky: completion received for a core with zero outstanding

Behaviour:
- Reset (async, rst_ni low): all FIFOs empty; cmd_ready_o all 1 once reset is released; cmd_valid_o=0; cmd_o='0; cmd_src_o=0; outstanding_o all 0; err_o=0; RR pointer=0.
- Input FIFO write: write when cmd_valid_i[i] && cmd_ready_o[i]. cmd_ready_o[i] = !full[i], driven combinationally from registered state only, with no dependence on cmd_valid_i.
- Eligibility:
  - core i is eligible when its FIFO is non-empty and outstanding[i] + pending[i] < MAX_OUTSTANDING.
  - pending[i] = 1 when the output slice holds an unaccepted command from core i.
- Arbitration:
  - Round-robin: the lowest eligible index at or after the pointer wins, wrapping at NUM_CORES-1 to 0.
  - After a grant, the pointer moves to winner+1 (mod NUM_CORES).
  - No grant in a cycle leaves the pointer unchanged.
- Output slice: single entry. It loads the winner (pop FIFO, capture cmd and index) when the slice is empty, or full and handshaking this cycle (cmd_valid_o && cmd_ready_i).
- Output stability: while cmd_valid_o && !cmd_ready_i, cmd_o and cmd_src_o are held stable; AXI-style, valid is never retracted.
- Latency: minimum 2 cycles from input handshake to cmd_valid_o (FIFO write at t, arbitrate and load at t+1, visible at t+2). Full throughput is 1 command/cycle with back-to-back ready.
- Outstanding counters:
  - outstanding[cmd_src_o] increments on each output handshake.
  - outstanding[cmd_resp_core_i] decrements on cmd_resp_valid_i.
  - If increment and decrement hit the same core in the same cycle, the count is unchanged.
  - A completion to a core at 0 leaves the count at 0 and sets err_o (cleared only by reset).
  - cmd_resp_core_i >= NUM_CORES is treated the same way and sets err_o.
- Throttling: a core at MAX_OUTSTANDING keeps its commands buffered but is skipped by the arbiter. cmd_ready_o still reflects only FIFO fullness.
- Simultaneous push and pop on one FIFO: allowed. Occupancy is unchanged; a full FIFO does not accept the push, since ready is already low.
- Reset mid-operation: all buffered and in-slice commands are discarded and counters are zeroed. There is no handshake with the uncluster.

Decomposition:
- pspin_cfg_pkg keeps pspin_cmd_t.
- Add to pspin_cfg_pkg: CLUSTER_CMD_FIFO_DEPTH and CLUSTER_CMD_MAX_OUTSTANDING defaults, plus a cmd_src_t typedef.
- One sub-module, cluster_cmd_fifo: a single-clock FIFO with full/empty flags and pop, instantiated NUM_CORES times.
- The arbiter, output slice and counters stay in the top level.

Test Plan:
- Single command: core 3 sends cmd A with cmd_ready_i=1. cmd_valid_o rises 2 cycles later with cmd_o=A, cmd_src_o=3, and outstanding_o[3]=1.
- Fairness: all 8 cores hold valid with 2 commands each and ready=1. Grant order is 0,1,...,7,0,...,7 with 16 outputs in 16 consecutive cycles.
- Backpressure: cmd_ready_i=0 for 5 cycles with core 2 valid. cmd_o and cmd_src_o stay stable and cmd_valid_o stays 1. Core 2 FIFO fills and cmd_ready_o[2]=0 after FIFO_DEPTH writes.
- Outstanding limit:
  - stimulus: core 0 sends 6 commands, no responses.
  - response: 4 issue, then cmd_valid_o drops; core 1 commands still issue.
  - stimulus: cmd_resp for core 0.
  - response: exactly one more core-0 command issues.
- Same-cycle completion on the issuing core: output handshake for core 5 plus cmd_resp_core_i=5 in the same cycle. outstanding_o[5] is unchanged.
- Error and reset: cmd_resp for core 6 at count 0 sets err_o=1 and the count stays 0. Asserting rst_ni=0 mid-burst clears cmd_valid_o, err_o and all counts immediately.
